ppu_bg_row_fetch: RTL and testbench

Multi-layer background row fetcher for the PPU: on each row-buffer swap it renders one scanline of NUM_LAYERS scrolled tile-map layers. Each layer has its own 9-bit X/Y scroll with 512-pixel wrap, and tiles support H/V flip and a 4-bit palette select. The block reads tile-map and pattern words over a fixed-latency VRAM read port and streams per-pixel writes into the row buffer. It succeeds the single-layer background path and adds multiple layers, flips, palette select and a parametrised VRAM latency.

---
 rtl/ppu_bg_row_fetch.sv | 248 ++++++++++++++++++++++++
 tb/tb_ppu_bg_row_fetch.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_bg_row_fetch.sv
// Multi-layer background row fetcher: per tile reads a map entry then a pattern row over a
// fixed-latency VRAM port and streams eight pixels (with H/V flip and palette) to the row buffer.
module ppu_bg_row_fetch #(
  parameter int unsigned NUM_LAYERS   = 2,
  parameter int unsigned ROW_PIXELS   = 320,
  parameter int unsigned VRAM_LATENCY = 2,
  parameter logic [15:0] PAT_BASE     = 16'h8000,
  localparam int unsigned LayerW      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [7:0]               row_i,
  input  logic [32*NUM_LAYERS-1:0] scroll_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     vram_rd_en_o,
  output logic [15:0]              vram_addr_o,
  input  logic [31:0]              vram_rddata_i,
  output logic                     pix_we_o,
  output logic [LayerW-1:0]        pix_layer_o,
  output logic [8:0]               pix_x_o,
  output logic [3:0]               pix_idx_o,
  output logic [3:0]               pix_pal_o
);

  localparam int unsigned Tiles = ROW_PIXELS / 8 + 1;
  localparam int unsigned WaitW = (VRAM_LATENCY > 1) ? $clog2(VRAM_LATENCY) : 1;
  localparam logic [WaitW-1:0]  WaitLast  = WaitW'(VRAM_LATENCY - 1);
  localparam logic [6:0]        ColLast   = 7'(Tiles - 1);
  localparam logic [LayerW-1:0] LayerLast = LayerW'(NUM_LAYERS - 1);
  localparam logic [9:0]        RowPix    = 10'(ROW_PIXELS);

  typedef enum logic [2:0] {
    StIdle,
    StMapRd,
    StMapWait,
    StPatRd,
    StPatWait,
    StEmit,
    StFin
  } state_e;

  state_e              state_q;
  logic [7:0]          row_q;
  logic [8:0]          sx_q [NUM_LAYERS];
  logic [8:0]          sy_q [NUM_LAYERS];
  logic [LayerW-1:0]   layer_q;
  logic [6:0]          col_q;
  logic [WaitW-1:0]    wait_q;
  logic [2:0]          emit_q;
  logic                hflip_q;
  logic [3:0]          pal_q;
  logic [31:0]         pat_q;

  logic                busy_q;
  logic                done_q;
  logic                rd_en_q;
  logic [15:0]         addr_q;
  logic                pix_we_q;
  logic [LayerW-1:0]   pix_layer_q;
  logic [8:0]          pix_x_q;
  logic [3:0]          pix_idx_q;
  logic [3:0]          pix_pal_q;

  logic                unused_scroll;
  assign unused_scroll = ^scroll_i;

  // Map word address: layer selects a 4096-word map, 64x64 tiles, column wraps at 64.
  function automatic logic [15:0] map_addr(input logic [LayerW-1:0] layer,
                                           input logic [7:0]        row,
                                           input logic [8:0]        sx,
                                           input logic [8:0]        sy,
                                           input logic [5:0]        col);
    logic [8:0] y;
    logic [5:0] tx;
    y  = {1'b0, row} + sy;
    tx = sx[8:3] + col;
    return {4'(layer), y[8:3], tx};
  endfunction

  logic [2:0]        cur_fx;
  logic [2:0]        cur_ry;
  logic              last_col;
  logic              last_layer;
  logic [6:0]        nxt_col;
  logic [LayerW-1:0] nxt_layer;
  logic [15:0]       nxt_addr;
  logic [15:0]       start_addr;
  logic [2:0]        ent_ry;
  logic [15:0]       pat_addr;
  logic [2:0]        em_i;
  logic [2:0]        em_nib;
  logic [31:0]       em_pat;
  logic [3:0]        em_idx;
  logic [9:0]        em_xp;
  logic [9:0]        em_fx;
  logic [9:0]        em_xs;
  logic              em_vis;

  always_comb begin
    cur_fx     = sx_q[layer_q][2:0];
    cur_ry     = row_q[2:0] + sy_q[layer_q][2:0];
    last_col   = (col_q == ColLast);
    last_layer = (layer_q == LayerLast);
    nxt_col    = last_col ? 7'd0 : col_q + 7'd1;
    nxt_layer  = (last_col && !last_layer) ? layer_q + LayerW'(1) : layer_q;
    nxt_addr   = map_addr(nxt_layer, row_q, sx_q[nxt_layer], sy_q[nxt_layer], nxt_col[5:0]);
    start_addr = map_addr('0, row_i, scroll_i[8:0], scroll_i[24:16], 6'd0);

    // Vertical flip mirrors the pattern row within the tile: 7-ry == ~ry.
    ent_ry   = vram_rddata_i[11] ? ~cur_ry : cur_ry;
    pat_addr = PAT_BASE + {3'b000, vram_rddata_i[9:0], ent_ry};

    // Pixel i=0 is produced straight from the arriving pattern word.
    em_i   = (state_q == StEmit) ? emit_q + 3'd1 : 3'd0;
    em_pat = (state_q == StEmit) ? pat_q : vram_rddata_i;
    em_nib = hflip_q ? ~em_i : em_i;
    em_idx = em_pat[{em_nib, 2'b00} +: 4];
    em_xp  = {col_q, 3'b000} + {7'd0, em_i};
    em_fx  = {7'd0, cur_fx};
    em_xs  = em_xp - em_fx;
    em_vis = (em_xp >= em_fx) && (em_xs < RowPix);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      row_q       <= '0;
      for (int l = 0; l < NUM_LAYERS; l++) begin
        sx_q[l] <= '0;
        sy_q[l] <= '0;
      end
      layer_q     <= '0;
      col_q       <= '0;
      wait_q      <= '0;
      emit_q      <= '0;
      hflip_q     <= 1'b0;
      pal_q       <= '0;
      pat_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      pix_we_q    <= 1'b0;
      pix_layer_q <= '0;
      pix_x_q     <= '0;
      pix_idx_q   <= '0;
      pix_pal_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        // A new start always wins, abandoning any row in flight without a done.
        row_q <= row_i;
        for (int l = 0; l < NUM_LAYERS; l++) begin
          sx_q[l] <= scroll_i[32*l +: 9];
          sy_q[l] <= scroll_i[32*l+16 +: 9];
        end
        layer_q  <= '0;
        col_q    <= '0;
        wait_q   <= '0;
        emit_q   <= '0;
        busy_q   <= 1'b1;
        rd_en_q  <= 1'b1;
        addr_q   <= start_addr;
        pix_we_q <= 1'b0;
        state_q  <= StMapRd;
      end else begin
        unique case (state_q)
          StIdle: ;
          StMapRd: begin
            rd_en_q <= 1'b0;
            wait_q  <= '0;
            state_q <= StMapWait;
          end
          StMapWait: begin
            if (wait_q == WaitLast) begin
              hflip_q <= vram_rddata_i[10];
              pal_q   <= vram_rddata_i[15:12];
              rd_en_q <= 1'b1;
              addr_q  <= pat_addr;
              state_q <= StPatRd;
            end else begin
              wait_q <= wait_q + WaitW'(1);
            end
          end
          StPatRd: begin
            rd_en_q <= 1'b0;
            wait_q  <= '0;
            state_q <= StPatWait;
          end
          StPatWait: begin
            if (wait_q == WaitLast) begin
              pat_q       <= vram_rddata_i;
              emit_q      <= '0;
              pix_we_q    <= em_vis;
              pix_layer_q <= layer_q;
              pix_x_q     <= em_xs[8:0];
              pix_idx_q   <= em_idx;
              pix_pal_q   <= pal_q;
              state_q     <= StEmit;
            end else begin
              wait_q <= wait_q + WaitW'(1);
            end
          end
          StEmit: begin
            if (emit_q == 3'd7) begin
              pix_we_q <= 1'b0;
              col_q    <= nxt_col;
              layer_q  <= nxt_layer;
              if (last_col && last_layer) begin
                done_q  <= 1'b1;
                state_q <= StFin;
              end else begin
                rd_en_q <= 1'b1;
                addr_q  <= nxt_addr;
                state_q <= StMapRd;
              end
            end else begin
              emit_q      <= emit_q + 3'd1;
              pix_we_q    <= em_vis;
              pix_layer_q <= layer_q;
              pix_x_q     <= em_xs[8:0];
              pix_idx_q   <= em_idx;
              pix_pal_q   <= pal_q;
            end
          end
          StFin: begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign vram_rd_en_o = rd_en_q;
  assign vram_addr_o  = addr_q;
  assign pix_we_o     = pix_we_q;
  assign pix_layer_o  = pix_layer_q;
  assign pix_x_o      = pix_x_q;
  assign pix_idx_o    = pix_idx_q;
  assign pix_pal_o    = pix_pal_q;

endmodule

// File: tb/tb_ppu_bg_row_fetch.sv
// Directed bench for ppu_bg_row_fetch: a VRAM model with fixed latency feeds one map entry and
// one pattern word; read addresses, pixel writes and done timing are checked per scenario.
module tb_ppu_bg_row_fetch;

  localparam int NL = 2;
  localparam int RP = 320;
  localparam int VL = 2;
  localparam int RowCycles = 1148;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  row = '0;
  logic [63:0] scroll = '0;
  logic        busy, done, vram_rd_en, pix_we;
  logic [15:0] vram_addr;
  logic [31:0] vram_rddata;
  logic [0:0]  pix_layer;
  logic [8:0]  pix_x;
  logic [3:0]  pix_idx, pix_pal;

  ppu_bg_row_fetch #(
    .NUM_LAYERS  (NL),
    .ROW_PIXELS  (RP),
    .VRAM_LATENCY(VL),
    .PAT_BASE    (16'h8000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .row_i        (row),
    .scroll_i     (scroll),
    .busy_o       (busy),
    .done_o       (done),
    .vram_rd_en_o (vram_rd_en),
    .vram_addr_o  (vram_addr),
    .vram_rddata_i(vram_rddata),
    .pix_we_o     (pix_we),
    .pix_layer_o  (pix_layer),
    .pix_x_o      (pix_x),
    .pix_idx_o    (pix_idx),
    .pix_pal_o    (pix_pal)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int first_rd_cyc = -1;
  int start_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  logic [15:0] map_entry = 16'h1003;
  logic [31:0] pat_word = 32'h89AB_CDEF;

  typedef struct {
    int layer;
    int x;
    int idx;
    int pal;
  } pix_t;
  pix_t        pix_q[$];
  logic [15:0] rd_q[$];

  // VRAM model: address captured each cycle, data presented VL cycles later.
  logic [15:0] pa [VL] = '{default: '0};
  always @(posedge clk) begin
    pa[0] <= vram_addr;
    for (int i = 1; i < VL; i++) pa[i] <= pa[i-1];
  end
  assign vram_rddata = pa[VL-1][15] ? pat_word : {16'hDEAD, map_entry};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vram_rd_en) begin
      rd_q.push_back(vram_addr);
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (pix_we) pix_q.push_back('{int'(pix_layer), int'(pix_x), int'(pix_idx), int'(pix_pal)});
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Counts departures from "each layer writes x=0..RP-1 ascending, layers ascending".
  function automatic int order_errors();
    int err = 0;
    int exp_x = 0;
    int cur_l = 0;
    foreach (pix_q[k]) begin
      if (pix_q[k].layer != cur_l) begin
        if (exp_x != RP) err++;
        if (pix_q[k].layer != cur_l + 1) err++;
        cur_l = pix_q[k].layer;
        exp_x = 0;
      end
      if (pix_q[k].x != exp_x) err++;
      exp_x++;
    end
    if (cur_l != NL - 1 || exp_x != RP) err++;
    return err;
  endfunction

  task automatic start_row(input logic [7:0] r, input logic [63:0] sc);
    first_rd_cyc = -1;
    rd_q.delete();
    pix_q.delete();
    @(negedge clk);
    start = 1'b1;
    row = r;
    scroll = sc;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int d0, output bit seen);
    for (int k = 0; k < 1400 && done_cnt == d0; k++) @(posedge clk);
    seen = (done_cnt != d0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    nvec++;
    if ({busy, done} !== 2'b00) begin
      nerr++; $display("FAIL reset_status: got busy/done=%b%b, expected 00", busy, done);
    end
    nvec++;
    if ({vram_rd_en, vram_addr} !== 17'd0) begin
      nerr++; $display("FAIL reset_vram: got en=%b addr=%h, expected 0/0000", vram_rd_en, vram_addr);
    end
    nvec++;
    if ({pix_we, pix_layer, pix_x, pix_idx, pix_pal} !== 19'd0) begin
      nerr++; $display("FAIL reset_pix: got we=%b x=%0d idx=%0d pal=%0d, expected all 0",
                       pix_we, pix_x, pix_idx, pix_pal);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int d0 = done_cnt;
    bit seen;
    map_entry = 16'h1003;
    pat_word = 32'h89AB_CDEF;
    start_row(8'd0, 64'd0);
    nvec++;
    if (busy !== 1'b1) begin
      nerr++; $display("FAIL basic_busy: got %b, expected 1", busy);
    end
    nvec++;
    if (vram_rd_en !== 1'b1 || vram_addr !== 16'h0000) begin
      nerr++; $display("FAIL basic_first_rd: got en=%b addr=%h, expected 1/0000", vram_rd_en, vram_addr);
    end
    wait_done(d0, seen);
    nvec++;
    if (!seen) begin
      nerr++; $display("FAIL basic_done_timeout: got no done, expected one");
    end
    nvec++;
    if (rd_q.size() != 164 || rd_q[1] !== 16'h8018 || rd_q[2] !== 16'h0001 || rd_q[82] !== 16'h1000) begin
      nerr++; $display("FAIL basic_addrs: got n=%0d pat=%h map1=%h l1=%h, expected 164/8018/0001/1000",
                       rd_q.size(), rd_q[1], rd_q[2], rd_q[82]);
    end
    nvec++;
    if (pix_q.size() != 640 || order_errors() != 0) begin
      nerr++; $display("FAIL basic_order: got n=%0d errs=%0d, expected 640/0", pix_q.size(), order_errors());
    end
    nvec++;
    if (pix_q[0].idx != 15 || pix_q[0].pal != 1 || pix_q[7].idx != 8) begin
      nerr++; $display("FAIL basic_idx: got %0d/%0d/%0d, expected 15/1/8",
                       pix_q[0].idx, pix_q[0].pal, pix_q[7].idx);
    end
    nvec++;
    if (done_cyc - first_rd_cyc != RowCycles || first_rd_cyc != start_cyc) begin
      nerr++; $display("FAIL basic_timing: got %0d (first rd lag %0d), expected %0d (0)",
                       done_cyc - first_rd_cyc, first_rd_cyc - start_cyc, RowCycles);
    end
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0 || done_cnt != d0 + 1) begin
      nerr++; $display("FAIL basic_end: got busy=%b done=%b dones=%0d, expected 0/0/1",
                       busy, done, done_cnt - d0);
    end
  endtask

  task automatic test_scroll_x();
    int d0 = done_cnt;
    bit seen;
    start_row(8'd0, 64'h0000_0000_0000_01FE);
    wait_done(d0, seen);
    nvec++;
    if (!seen || rd_q[0] !== 16'h003F || rd_q[2] !== 16'h0000 || rd_q[82] !== 16'h1000) begin
      nerr++; $display("FAIL scrollx_addrs: got %h/%h/%h, expected 003F/0000/1000",
                       rd_q[0], rd_q[2], rd_q[82]);
    end
    nvec++;
    if (pix_q[0].x != 0 || pix_q[0].idx != 9 || pix_q[1].x != 1 || pix_q[1].idx != 8 ||
        pix_q[2].x != 2 || pix_q[2].idx != 15) begin
      nerr++; $display("FAIL scrollx_edge: got x/idx %0d/%0d %0d/%0d %0d/%0d, expected 0/9 1/8 2/15",
                       pix_q[0].x, pix_q[0].idx, pix_q[1].x, pix_q[1].idx, pix_q[2].x, pix_q[2].idx);
    end
    nvec++;
    if (pix_q.size() != 640 || order_errors() != 0 || done_cyc - first_rd_cyc != RowCycles) begin
      nerr++; $display("FAIL scrollx_row: got n=%0d errs=%0d cycles=%0d, expected 640/0/%0d",
                       pix_q.size(), order_errors(), done_cyc - first_rd_cyc, RowCycles);
    end
  endtask

  task automatic test_flip();
    int d0 = done_cnt;
    int bad = 0;
    bit seen;
    map_entry = 16'h5C03;
    pat_word = 32'h7654_3210;
    start_row(8'd2, 64'd0);
    wait_done(d0, seen);
    nvec++;
    if (!seen || rd_q[1] !== 16'h801D) begin
      nerr++; $display("FAIL flip_pat_addr: got %h, expected 801D", rd_q[1]);
    end
    for (int i = 0; i < 8; i++) if (pix_q[i].idx != 7 - i || pix_q[i].pal != 5) bad++;
    nvec++;
    if (bad != 0) begin
      nerr++; $display("FAIL flip_hseq: got %0d bad pixels, expected 0", bad);
    end
    nvec++;
    if (pix_q[320].layer != 1 || pix_q[320].idx != 7 || pix_q[320].pal != 5) begin
      nerr++; $display("FAIL flip_layer1: got l=%0d idx=%0d pal=%0d, expected 1/7/5",
                       pix_q[320].layer, pix_q[320].idx, pix_q[320].pal);
    end
    map_entry = 16'h1003;
    pat_word = 32'h89AB_CDEF;
  endtask

  task automatic test_scroll_y();
    int d0 = done_cnt;
    bit seen;
    start_row(8'd10, 64'h01FC_0000_0000_0000);
    wait_done(d0, seen);
    nvec++;
    if (!seen || rd_q[0] !== 16'h0040 || rd_q[1] !== 16'h801A) begin
      nerr++; $display("FAIL scrolly_l0: got %h/%h, expected 0040/801A", rd_q[0], rd_q[1]);
    end
    nvec++;
    if (rd_q[82] !== 16'h1000 || rd_q[83] !== 16'h801E || rd_q[84] !== 16'h1001) begin
      nerr++; $display("FAIL scrolly_l1: got %h/%h/%h, expected 1000/801E/1001",
                       rd_q[82], rd_q[83], rd_q[84]);
    end
  endtask

  task automatic test_restart();
    int d0 = done_cnt;
    int pn;
    int restart_cyc;
    bit seen;
    start_row(8'd0, 64'd0);
    repeat (299) @(negedge clk);
    start = 1'b1;
    row = 8'd8;
    @(negedge clk);
    start = 1'b0;
    restart_cyc = cyc;
    pn = pix_q.size();
    nvec++;
    if (vram_rd_en !== 1'b1 || vram_addr !== 16'h0040 || busy !== 1'b1) begin
      nerr++; $display("FAIL restart_rd: got en=%b addr=%h busy=%b, expected 1/0040/1",
                       vram_rd_en, vram_addr, busy);
    end
    wait_done(d0, seen);
    nvec++;
    if (!seen || done_cnt != d0 + 1 || done_cyc - restart_cyc != RowCycles) begin
      nerr++; $display("FAIL restart_done: got dones=%0d at +%0d, expected 1 at +%0d",
                       done_cnt - d0, done_cyc - restart_cyc, RowCycles);
    end
    nvec++;
    if (pix_q.size() - pn != 640) begin
      nerr++; $display("FAIL restart_pix: got %0d writes, expected 640", pix_q.size() - pn);
    end
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt;
    int k;
    bit seen;
    start_row(8'd0, 64'd0);
    for (k = 0; k < 100 && pix_we !== 1'b1; k++) @(negedge clk);
    nvec++;
    if (pix_we !== 1'b1) begin
      nerr++; $display("FAIL rstmid_emit: got pix_we=%b, expected 1 within 100 cycles", pix_we);
    end
    #1 rst_n = 1'b0;
    #1;
    nvec++;
    if ({busy, done, vram_rd_en, vram_addr, pix_we, pix_layer, pix_x, pix_idx, pix_pal} !== 38'd0) begin
      nerr++; $display("FAIL rstmid_async: got busy=%b en=%b addr=%h we=%b idx=%0d pal=%0d, expected all 0",
                       busy, vram_rd_en, vram_addr, pix_we, pix_idx, pix_pal);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (1300) @(posedge clk);
    nvec++;
    if (done_cnt != d0) begin
      nerr++; $display("FAIL rstmid_nodone: got %0d dones, expected 0", done_cnt - d0);
    end
    start_row(8'd0, 64'd0);
    wait_done(d0, seen);
    nvec++;
    if (!seen || pix_q.size() != 640 || order_errors() != 0 || done_cyc - first_rd_cyc != RowCycles) begin
      nerr++; $display("FAIL rstmid_rerun: got n=%0d errs=%0d cycles=%0d, expected 640/0/%0d",
                       pix_q.size(), order_errors(), done_cyc - first_rd_cyc, RowCycles);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_scroll_x();
    test_flip();
    test_scroll_y();
    test_restart();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
